cpu_control_unit: RTL and testbench
===================================

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 The block SHALL have the following ports.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word offered.
- instr_ready  out  1  block can accept an instruction.
- instr  in  16  instruction word: op=[15:11], rd=[10:8], ra=[7:5], rb=[4:2], imm5=[4:0], imm8=[7:0].
- S_out  in  16  datapath ALU result.
- N, Z, V, C  in  1 each  datapath ALU flags.
- RF_en  out  1  register-file write enable.
- RF_addr  out  3  register-file write address.
- RF_data  out  16  register-file write data.
- read_A, read_B  out  3 each  register-file read addresses.
- add_or_sub  out  1  0 = add, 1 = subtract.
- out_imm  out  1  1 = ALU B operand is ext_B_data.
- ext_B_data  out  16  immediate operand.
- LHI, LLI  out  1 each  load-high / load-low immediate select.
- ctro_outR  out  1  load the datapath output register.
- flags  out  4  registered {N,Z,V,C}.
- done  out  1  one-cycle retire pulse.
- err  out  1  one-cycle illegal-opcode pulse.

Function
REQ-002 The state machine SHALL have four states: IDLE, DECODE, EXEC and WB.
REQ-003 IDLE: instr_ready SHALL be 1 only in IDLE; on instr_valid & instr_ready the block SHALL latch instr into ir and go to DECODE. instr is ignored in every other state.
REQ-004 Opcodes SHALL be:
- 00000 NOP
- 00001 ADD rd,ra,rb
- 00010 SUB rd,ra,rb
- 00011 ADDI rd,ra,imm5
- 00100 SUBI rd,ra,imm5
- 00101 LHI rd,imm8
- 00110 LLI rd,imm8
- 00111 OUT ra
- any other opcode is illegal.
REQ-005 In DECODE, EXEC and WB the datapath controls SHALL be driven combinationally from ir:
- read_A = ra.
- read_B = rb for ADD/SUB; otherwise read_B = rd.
- add_or_sub = 1 for SUB/SUBI only.
- out_imm = 1 for ADDI/SUBI/LHI/LLI.
- ext_B_data = sign-extended imm5 for ADDI/SUBI; {8'h00, imm8} for LHI/LLI; 0 otherwise.
- LHI = 1 only for the LHI opcode; LLI = 1 only for the LLI opcode.
- In IDLE all of these outputs SHALL be 0.
REQ-006 DECODE SHALL last exactly one cycle and then go to EXEC.
REQ-007 EXEC SHALL last one cycle:
- For ADD/SUB/ADDI/SUBI/LHI/LLI: capture S_out into the result register, capture {N,Z,V,C} into flags, go to WB.
- For OUT: ctro_outR = 1 for this cycle, done = 1, go to IDLE; flags unchanged.
- For NOP: done = 1, go to IDLE.
- For an illegal opcode: err = 1, done = 1, go to IDLE; no RF write and no flags update.
REQ-008 WB SHALL last one cycle with RF_en = 1, RF_addr = rd, RF_data = result and done = 1, then go to IDLE.
REQ-009 RF_en SHALL be 1 only in WB. ctro_outR SHALL be 1 only in EXEC of OUT. RF_addr and RF_data SHALL be 0 outside WB.
REQ-010 Latency, with the handshake edge as cycle 0:
- writing instructions: done in cycle 3;
- NOP/OUT/illegal: done in cycle 2;
- earliest next handshake: the cycle after done.
REQ-011 A write to rd = 0 SHALL be performed like any other register (no hardwired zero).
REQ-012 Holding instr_valid high continuously SHALL yield back-to-back instructions with no lost or duplicated accept.

Reset
REQ-013 When rst = 1 at a clock edge the block SHALL:
- go to IDLE;
- clear ir, result and flags to 0;
- abort any instruction in flight with no RF write, done or err.
REQ-014 In the cycle after reset, every output except instr_ready SHALL be 0 and instr_ready SHALL be 1.

Verification
REQ-015 ADD: instr = {00001,001,010,011,00}, S_out = 16'h0005 in EXEC -> cycle 3: RF_en = 1, RF_addr = 1, RF_data = 16'h0005, done = 1. In DECODE: read_A = 2, read_B = 3.
REQ-016 SUBI with imm5 = 5'b11111 -> ext_B_data = 16'hFFFF, add_or_sub = 1, out_imm = 1. With N=1, Z=0, V=0, C=1 in EXEC -> flags = 4'b1001.
REQ-017 LHI rd = 7, imm8 = 8'hAA -> ext_B_data = 16'h00AA, LHI = 1, LLI = 0, RF_addr = 7 in WB.
REQ-018 OUT ra = 5 -> cycle 2: ctro_outR = 1, read_A = 5, done = 1, RF_en = 0 throughout.
REQ-019 Opcode 11111 -> cycle 2: err = 1, done = 1; no RF_en; flags unchanged.
REQ-020 rst asserted while in EXEC of an ADD -> no WB cycle occurs, RF_en stays 0, next cycle instr_ready = 1. Separately, instr_valid held high for three ADDs -> three done pulses, one every 4 cycles.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit: accepts one 16-bit instruction, then sequences
// decode, execute and register-file write-back for an external ALU datapath.
module cpu_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic [15:0] S_out,
    input  logic        N,
    input  logic        Z,
    input  logic        V,
    input  logic        C,
    output logic        RF_en,
    output logic [2:0]  RF_addr,
    output logic [15:0] RF_data,
    output logic [2:0]  read_A,
    output logic [2:0]  read_B,
    output logic        add_or_sub,
    output logic        out_imm,
    output logic [15:0] ext_B_data,
    output logic        LHI,
    output logic        LLI,
    output logic        ctro_outR,
    output logic [3:0]  flags,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_SUB  = 5'd2,
        OP_ADDI = 5'd3,
        OP_SUBI = 5'd4,
        OP_LHI  = 5'd5,
        OP_LLI  = 5'd6,
        OP_OUT  = 5'd7
    } op_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;
    logic [15:0] result;

    logic [4:0]  op;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [4:0]  imm5;
    logic [7:0]  imm8;
    logic        is_write;
    logic        is_legal;

    assign op   = ir[15:11];
    assign rd   = ir[10:8];
    assign ra   = ir[7:5];
    assign rb   = ir[4:2];
    assign imm5 = ir[4:0];
    assign imm8 = ir[7:0];

    assign is_write = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) ||
                      (op == OP_SUBI) || (op == OP_LHI) || (op == OP_LLI);
    assign is_legal = is_write || (op == OP_NOP) || (op == OP_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ir     <= '0;
            result <= '0;
            flags  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && instr_valid) begin
                ir <= instr;
            end
            // Result and flags only move for register-writing opcodes.
            if (state == EXEC && is_write) begin
                result <= S_out;
                flags  <= {N, Z, V, C};
            end
        end
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        RF_en       = 1'b0;
        RF_addr     = '0;
        RF_data     = '0;
        read_A      = '0;
        read_B      = '0;
        add_or_sub  = 1'b0;
        out_imm     = 1'b0;
        ext_B_data  = '0;
        LHI         = 1'b0;
        LLI         = 1'b0;
        ctro_outR   = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        if (state != IDLE) begin
            read_A     = ra;
            read_B     = (op == OP_ADD || op == OP_SUB) ? rb : rd;
            add_or_sub = (op == OP_SUB) || (op == OP_SUBI);
            out_imm    = (op == OP_ADDI) || (op == OP_SUBI) ||
                         (op == OP_LHI) || (op == OP_LLI);
            if (op == OP_ADDI || op == OP_SUBI) begin
                ext_B_data = {{11{imm5[4]}}, imm5};
            end else if (op == OP_LHI || op == OP_LLI) begin
                ext_B_data = {8'h00, imm8};
            end
            LHI = (op == OP_LHI);
            LLI = (op == OP_LLI);
        end

        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                state_next = EXEC;
            end
            EXEC: begin
                if (is_write) begin
                    state_next = WB;
                end else begin
                    state_next = IDLE;
                    done       = 1'b1;
                    err        = !is_legal;
                    ctro_outR  = (op == OP_OUT);
                end
            end
            WB: begin
                RF_en      = 1'b1;
                RF_addr    = rd;
                RF_data    = result;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized bench for cpu_control_unit: each instruction is checked cycle by
// cycle against expectations derived from its opcode fields and latency.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] S_out;
    logic        N, Z, V, C;
    logic        RF_en;
    logic [2:0]  RF_addr;
    logic [15:0] RF_data;
    logic [2:0]  read_A, read_B;
    logic        add_or_sub, out_imm;
    logic [15:0] ext_B_data;
    logic        LHI, LLI, ctro_outR;
    logic [3:0]  flags;
    logic        done, err;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    logic [3:0]  exp_flags;
    int unsigned done_q[$];

    cpu_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .S_out      (S_out),
        .N          (N),
        .Z          (Z),
        .V          (V),
        .C          (C),
        .RF_en      (RF_en),
        .RF_addr    (RF_addr),
        .RF_data    (RF_data),
        .read_A     (read_A),
        .read_B     (read_B),
        .add_or_sub (add_or_sub),
        .out_imm    (out_imm),
        .ext_B_data (ext_B_data),
        .LHI        (LHI),
        .LLI        (LLI),
        .ctro_outR  (ctro_outR),
        .flags      (flags),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] strobes(input bit ready, input bit rf_en,
                                            input logic [2:0] addr, input logic [15:0] data,
                                            input bit outr, input bit dn, input bit er);
        return {ready, rf_en, addr, data, outr, dn, er};
    endfunction

    task automatic cycle_check(input string tag, input logic [25:0] e_ctrl, input logic [23:0] e_strb);
        check({tag, ".ctrl"},
              {6'b0, read_A, read_B, add_or_sub, out_imm, ext_B_data, LHI, LLI}, {6'b0, e_ctrl});
        check({tag, ".strb"},
              {8'b0, instr_ready, RF_en, RF_addr, RF_data, ctro_outR, done, err}, {8'b0, e_strb});
        check({tag, ".flags"}, {28'b0, flags}, {28'b0, exp_flags});
    endtask

    task automatic randomize_dp();
        S_out = 16'($urandom);
        {N, Z, V, C} = 4'($urandom);
    endtask

    // Called right after a rising edge with the DUT idle; returns likewise.
    task automatic run_instr(input logic [15:0] w, input logic [15:0] s_val,
                             input logic [3:0] nzvc, input bit hold);
        int op, rd, ra, rb, imm5, imm8, se;
        bit writes, legal;
        logic [15:0] e_ext;
        logic [25:0] e_ctrl;
        op   = int'(w[15:11]);
        rd   = int'(w[10:8]);
        ra   = int'(w[7:5]);
        rb   = int'(w[4:2]);
        imm5 = int'(w[4:0]);
        imm8 = int'(w[7:0]);
        se   = (imm5 >= 16) ? imm5 - 32 : imm5;
        writes = (op >= 1 && op <= 6);
        legal  = (op <= 7);
        e_ext  = (op == 3 || op == 4) ? 16'(se) : (op == 5 || op == 6) ? 16'(imm8) : 16'd0;
        e_ctrl = {3'(ra), 3'((op == 1 || op == 2) ? rb : rd), (op == 2 || op == 4),
                  (op >= 3 && op <= 6), e_ext, (op == 5), (op == 6)};

        instr_valid = 1'b1;
        instr = w;
        randomize_dp();
        @(negedge clk);
        cycle_check("idle", '0, strobes(1, 0, 3'd0, 16'd0, 0, 0, 0));

        @(posedge clk); #1;
        if (!hold) instr_valid = 1'b0;
        instr = 16'($urandom);
        randomize_dp();
        @(negedge clk);
        cycle_check("decode", e_ctrl, strobes(0, 0, 3'd0, 16'd0, 0, 0, 0));

        @(posedge clk); #1;
        instr = 16'($urandom);
        S_out = s_val;
        {N, Z, V, C} = nzvc;
        @(negedge clk);
        cycle_check("exec", e_ctrl, strobes(0, 0, 3'd0, 16'd0, op == 7, !writes, !legal));

        @(posedge clk); #1;
        if (writes) begin
            exp_flags = nzvc;
            instr = 16'($urandom);
            randomize_dp();
            @(negedge clk);
            cycle_check("wb", e_ctrl, strobes(0, 1, 3'(rd), s_val, 0, 1, 0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int op;
        logic [15:0] w;

        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        randomize_dp();
        exp_flags = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cycle_check("reset", '0, strobes(1, 0, 3'd0, 16'd0, 0, 0, 0));
        @(posedge clk); #1;

        run_instr({5'b00001, 3'd1, 3'd2, 3'd3, 2'b00}, 16'h0005, 4'b0000, 0);
        run_instr({5'b00100, 3'd4, 3'd6, 5'b11111}, 16'h1234, 4'b1001, 0);
        check("subi_flags", {28'b0, flags}, 32'h9);
        run_instr({5'b00101, 3'd7, 8'hAA}, 16'hAA00, 4'b0100, 0);
        run_instr({5'b00111, 3'd0, 3'd5, 5'd0}, 16'hBEEF, 4'b1111, 0);
        run_instr({5'b11111, 11'h5A5}, 16'hCAFE, 4'b0110, 0);
        run_instr({5'b00011, 3'd0, 3'd3, 5'b01111}, 16'h7777, 4'b0010, 0);
        run_instr({5'b00000, 11'h7FF}, 16'h0101, 4'b1111, 0);

        // Reset while an ADD is in EXEC: no write-back may follow.
        instr_valid = 1'b1;
        instr = {5'b00001, 3'd2, 3'd1, 3'd1, 2'b00};
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_flags = '0;
        @(negedge clk);
        cycle_check("rst_exec", '0, strobes(1, 0, 3'd0, 16'd0, 0, 0, 0));
        @(posedge clk); #1;

        done_q.delete();
        for (int i = 0; i < 3; i++) begin
            run_instr({5'b00001, 3'(i), 3'd4, 3'd5, 2'b00}, 16'(100 + i), 4'(i), 1);
        end
        instr_valid = 1'b0;
        check("b2b_count", done_q.size(), 3);
        if (done_q.size() == 3) begin
            check("b2b_gap1", done_q[1] - done_q[0], 4);
            check("b2b_gap2", done_q[2] - done_q[1], 4);
        end

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op > 7) op = $urandom_range(8, 31);
            w = {5'(op), 11'($urandom)};
            run_instr(w, 16'($urandom), 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                instr_valid = 1'b0;
                randomize_dp();
                @(negedge clk);
                cycle_check("gap", '0, strobes(1, 0, 3'd0, 16'd0, 0, 0, 0));
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
